// File: rtl/fetch_queue.sv
// fetch_queue
//   DEPTH-entry instruction queue between instruction fetch and decode.
//   Each entry carries {pc, pc_plus_4, instruction}. Fetch may run ahead of
//   decode by up to DEPTH instructions.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset (0 = in reset)
//   busywait        global memory stall, freezes all queue state
//   flush           jump/branch redirect, discards every entry
//   in_valid        fetch presents an entry
//   in_ready        queue accepts an entry this cycle
//   in_pc           PC of the fetched instruction
//   in_pc_plus_4    PC+4 of the fetched instruction
//   in_instruction  fetched instruction word
//   out_valid       head entry available to decode
//   out_ready       decode consumes the head this cycle
//   out_pc          head PC (0 when empty)
//   out_pc_plus_4   head PC+4 (0 when empty)
//   out_instruction head instruction (NOP_INSTR when empty)
//   count           number of occupied entries
module fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013,
    parameter int              CW        = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            busywait,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_pc_plus_4,
    input  logic [ILEN-1:0] in_instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus_4,
    output logic [ILEN-1:0] out_instruction,
    output logic [CW-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 2 * XLEN + ILEN;

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic          push;
    logic          pop;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready deliberately ignores out_ready: no decode-to-fetch comb path,
    // so a full queue refuses a push even when the head is being popped.
    assign in_ready  = reset & ~busywait & ~flush & (count_reg < CW'(DEPTH));
    assign out_valid = (count_reg != '0) & ~busywait & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // busywait already forces push/pop low, so state simply holds.
            if (push) wr_ptr_next = advance(wr_ptr_reg);
            if (pop)  rd_ptr_next = advance(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is not reset; count gates whether its contents are visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_pc, in_pc_plus_4, in_instruction};
        end
    end

    assign head = mem[rd_ptr_reg];

    always_comb begin
        out_pc          = '0;
        out_pc_plus_4   = '0;
        out_instruction = NOP_INSTR;
        if (count_reg != '0) begin
            out_pc          = head[EW-1 -: XLEN];
            out_pc_plus_4   = head[ILEN +: XLEN];
            out_instruction = head[ILEN-1:0];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed test of fetch_queue (DEPTH=4). A queue-based reference model
//   predicts every output each cycle; hand-computed literal expectations pin
//   the model and the specific scenarios (fill, wrap drain, stream, flush,
//   busywait freeze, asynchronous reset).
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        busywait;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_pc_plus_4;
    logic [31:0] in_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;
    logic [31:0] out_instruction;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .busywait        (busywait),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_pc_plus_4    (in_pc_plus_4),
        .in_instruction  (in_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_pc_plus_4   (out_pc_plus_4),
        .out_instruction (out_instruction),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [31:0] dut_pops[$];

    always @(posedge clk or negedge reset) begin
        bit   can_push;
        bit   can_pop;
        ent_t e;
        if (!reset) begin
            q.delete();
        end else begin
            can_push = !busywait && !flush && (q.size() < DEPTH);
            can_pop  = (q.size() != 0) && !busywait && !flush;
            if (flush) begin
                q.delete();
            end else begin
                if (can_pop && out_ready) void'(q.pop_front());
                if (can_push && in_valid) begin
                    e.pc  = in_pc;
                    e.pc4 = in_pc_plus_4;
                    e.ins = in_instruction;
                    q.push_back(e);
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        bit          e_rdy;
        bit          e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_ins;
        e_rdy = reset && !busywait && !flush && (q.size() < DEPTH);
        e_vld = (q.size() != 0) && !busywait && !flush;
        e_pc  = (q.size() != 0) ? q[0].pc  : 32'h0;
        e_pc4 = (q.size() != 0) ? q[0].pc4 : 32'h0;
        e_ins = (q.size() != 0) ? q[0].ins : NOP;
        check("model_in_ready",  64'(in_ready),        64'(e_rdy));
        check("model_out_valid", 64'(out_valid),       64'(e_vld));
        check("model_count",     64'(count),           64'(q.size()));
        check("model_out_pc",    64'(out_pc),          64'(e_pc));
        check("model_out_pc4",   64'(out_pc_plus_4),   64'(e_pc4));
        check("model_out_instr", 64'(out_instruction), 64'(e_ins));
        if (in_valid && in_ready) $display("push pc=%08h instr=%08h", in_pc, in_instruction);
        if (out_valid && out_ready) begin
            $display("pop  pc=%08h instr=%08h", out_pc, out_instruction);
            dut_pops.push_back(out_pc);
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle of inputs, report whether in_ready was high before the edge.
    task automatic step(input logic iv, input logic [31:0] pc, input logic ordy,
                        input logic bw, input logic fl, output logic acc);
        in_valid       = iv;
        in_pc          = pc;
        in_pc_plus_4   = pc + 32'd4;
        in_instruction = ins_of(pc);
        out_ready      = ordy;
        busywait       = bw;
        flush          = fl;
        #1;
        acc = in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        acc;
        logic [31:0] pc;
        logic [31:0] head;

        reset = 1'b0; busywait = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_pc_plus_4 = '0; in_instruction = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),        64'd0);
        check("rst_out_valid", 64'(out_valid),       64'd0);
        check("rst_count",     64'(count),           64'd0);
        check("rst_out_pc",    64'(out_pc),          64'd0);
        check("rst_out_instr", 64'(out_instruction), 64'h13);
        reset = 1'b1;

        // Fill with decode stalled.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b0, acc);
            check("fill_count", 64'(count), 64'(i + 1));
            check("fill_head_pc", 64'(out_pc), 64'h0);
            check("fill_head_instr", 64'(out_instruction), 64'hA000_0000);
        end
        check("full_in_ready", 64'(in_ready), 64'd0);

        // Drain from full with fetch still pushing; pointers wrap several times.
        pc = 32'h10;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, pc, 1'b1, 1'b0, 1'b0, acc);
            if (i == 0) begin
                check("full_pop_refuses_push", 64'(acc), 64'd0);
                check("full_pop_count", 64'(count), 64'd3);
                check("in_ready_after_full_pop", 64'(in_ready), 64'd1);
            end
            if (acc) pc = pc + 32'd4;
            check("count_le_depth", 64'(count <= 3'd4), 64'd1);
        end
        check("drain_head_pc", 64'(out_pc), 64'h30);
        repeat (2) step(1'b0, pc, 1'b1, 1'b0, 1'b0, acc);
        check("pre_stream_count", 64'(count), 64'd1);

        // Steady stream at one entry per cycle.
        head = 32'h38;
        check("stream_start_head", 64'(out_pc), 64'h38);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, pc, 1'b1, 1'b0, 1'b0, acc);
            check("stream_accept", 64'(acc), 64'd1);
            pc   = pc + 32'd4;
            head = head + 32'd4;
            check("stream_count", 64'(count), 64'd1);
            check("stream_head_pc", 64'(out_pc), 64'(head));
            check("stream_head_pc4", 64'(out_pc_plus_4), 64'(head + 32'd4));
        end

        // Everything popped so far must be 0x0,0x4,... with no gap or repeat.
        check("pop_total", 64'(dut_pops.size()), 64'd34);
        for (int i = 0; i < dut_pops.size(); i++) begin
            check("pop_order", 64'(dut_pops[i]), 64'(4 * i));
        end

        // Flush with 3 entries, together with an offered push of 0x40.
        repeat (2) begin
            step(1'b1, pc, 1'b0, 1'b0, 1'b0, acc);
            pc = pc + 32'd4;
        end
        check("preflush_count", 64'(count), 64'd3);
        step(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, acc);
        check("flush_in_ready", 64'(acc), 64'd0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_instr", 64'(out_instruction), 64'h13);
        check("flush_out_pc", 64'(out_pc), 64'h0);
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, acc);
        check("postflush_head", 64'(out_pc), 64'h200);
        check("postflush_count", 64'(count), 64'd1);

        // Busywait freeze with 2 entries.
        step(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h208, 1'b1, 1'b1, 1'b0, acc);
            check("bw_accept", 64'(acc), 64'd0);
            check("bw_count", 64'(count), 64'd2);
            check("bw_in_ready", 64'(in_ready), 64'd0);
            check("bw_out_valid", 64'(out_valid), 64'd0);
            check("bw_out_pc", 64'(out_pc), 64'h200);
        end
        step(1'b1, 32'h208, 1'b1, 1'b0, 1'b0, acc);
        check("bw_resume_accept", 64'(acc), 64'd1);
        check("bw_resume_count", 64'(count), 64'd2);
        check("bw_resume_head", 64'(out_pc), 64'h204);

        // Asynchronous reset between clock edges with 3 entries.
        step(1'b1, 32'h20C, 1'b0, 1'b0, 1'b0, acc);
        check("prereset_count", 64'(count), 64'd3);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd0);
        check("async_rst_out_instr", 64'(out_instruction), 64'h13);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, acc);
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_head", 64'(out_pc), 64'h300);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
        check("post_rst_empty", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
